// File: rtl/dat_mem_arb_pkg.sv
// dat_mem_arb_pkg: shared state encoding and sizing helpers for the dat_mem arbiter.
`default_nettype none

package dat_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int NUM_PORTS = 2;

  function automatic int burst_w(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dat_mem_arb_rr.sv
// dat_mem_arb_rr: round-robin ownership FSM with bounded burst length.
`default_nettype none

module dat_mem_arb_rr
  import dat_mem_arb_pkg::*;
#(
  parameter int MaxBurst = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  output arb_state_t state
);

  localparam int             BW      = burst_w(MaxBurst);
  localparam logic [BW-1:0]  CNT_MAX = BW'(MaxBurst - 1);

  arb_state_t    state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;

  logic       own_id;
  logic       own_req;
  logic       oth_req;
  arb_state_t oth_state;

  assign own_id    = (state_q == OWN1);
  assign own_req   = own_id ? req1 : req0;
  assign oth_req   = own_id ? req0 : req1;
  assign oth_state = own_id ? OWN0 : OWN1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        // On a tie the port that did not own the memory last wins.
        if (req0 && (!req1 || last_q)) begin
          state_d = OWN0;
          cnt_d   = '0;
        end else if (req1) begin
          state_d = OWN1;
          cnt_d   = '0;
        end
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          state_d = oth_req ? oth_state : IDLE;
          cnt_d   = '0;
          last_d  = own_id;
        end else if (oth_req && (cnt_q == CNT_MAX)) begin
          state_d = oth_state;
          cnt_d   = '0;
          last_d  = own_id;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign state = state_q;

endmodule

`default_nettype wire

// File: rtl/dat_mem_arb.sv
// dat_mem_arb: two-port round-robin arbiter in front of the single-port dat_mem.
// Optional grant/conflict statistics counters enabled by DAT_MEM_ARB_STATS_EN.
`default_nettype none

module dat_mem_arb
  import dat_mem_arb_pkg::*;
#(
  parameter int AW       = 8,
  parameter int MaxBurst = 4
) (
  input  logic          CLK,
  input  logic          ResetN,
  input  logic          Req0,
  input  logic          Req1,
  input  logic          We0,
  input  logic          We1,
  input  logic [AW-1:0] Adr0,
  input  logic [AW-1:0] Adr1,
  input  logic [7:0]    Wdata0,
  input  logic [7:0]    Wdata1,
  output logic          Gnt0,
  output logic          Gnt1,
  output logic [7:0]    Rdata0,
  output logic [7:0]    Rdata1,
  output logic          RValid0,
  output logic          RValid1,
  output logic [AW-1:0] MemAdr,
  output logic          ReadMem,
  output logic          WriteMem,
  output logic [7:0]    MemDataIn,
  input  logic [7:0]    MemDataOut
`ifdef DAT_MEM_ARB_STATS_EN
  ,
  output logic [15:0]   GntCnt0,
  output logic [15:0]   GntCnt1,
  output logic [15:0]   ConflictCnt
`endif
);

  arb_state_t           state;
  logic [NUM_PORTS-1:0] gnt;

  dat_mem_arb_rr #(
    .MaxBurst(MaxBurst)
  ) u_rr (
    .clk  (CLK),
    .rst_n(ResetN),
    .req0 (Req0),
    .req1 (Req1),
    .state(state)
  );

  assign gnt[0] = (state == OWN0) && Req0;
  assign gnt[1] = (state == OWN1) && Req1;
  assign Gnt0   = gnt[0];
  assign Gnt1   = gnt[1];

  always_comb begin
    MemAdr    = '0;
    MemDataIn = '0;
    WriteMem  = 1'b0;
    ReadMem   = 1'b0;
    if (gnt[0]) begin
      MemAdr    = Adr0;
      MemDataIn = Wdata0;
      WriteMem  = We0;
      ReadMem   = !We0;
    end else if (gnt[1]) begin
      MemAdr    = Adr1;
      MemDataIn = Wdata1;
      WriteMem  = We1;
      ReadMem   = !We1;
    end
  end

  // dat_mem reads combinationally, so the data is captured on the grant edge.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      Rdata0  <= '0;
      Rdata1  <= '0;
      RValid0 <= 1'b0;
      RValid1 <= 1'b0;
    end else begin
      RValid0 <= gnt[0] && !We0;
      RValid1 <= gnt[1] && !We1;
      if (gnt[0] && !We0) Rdata0 <= MemDataOut;
      if (gnt[1] && !We1) Rdata1 <= MemDataOut;
    end
  end

`ifdef DAT_MEM_ARB_STATS_EN
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      GntCnt0     <= '0;
      GntCnt1     <= '0;
      ConflictCnt <= '0;
    end else begin
      if (gnt[0] && (GntCnt0 != 16'hFFFF)) GntCnt0 <= GntCnt0 + 16'd1;
      if (gnt[1] && (GntCnt1 != 16'hFFFF)) GntCnt1 <= GntCnt1 + 16'd1;
      if (Req0 && Req1 && (ConflictCnt != 16'hFFFF)) ConflictCnt <= ConflictCnt + 16'd1;
    end
  end
`else
  // Statistics build option off: no counters.
`endif

endmodule

`default_nettype wire

// File: tb/tb_dat_mem_arb.sv
// tb_dat_mem_arb: directed scoreboard bench for dat_mem_arb (MaxBurst=4 and MaxBurst=1 instances).
`default_nettype none

module tb_dat_mem_arb;

  typedef struct packed {
    logic       port;
    logic       we;
    logic [7:0] adr;
    logic [7:0] wd;
  } gexp_t;

  typedef struct packed {
    logic       port;
    logic [7:0] data;
  } rexp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: MaxBurst = 4
  logic       req0, req1, we0, we1;
  logic [7:0] adr0, adr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, read_mem, write_mem;
  logic [7:0] rdata0, rdata1, mem_adr, mem_din, mem_dout;

  // Instance B: MaxBurst = 1
  logic       b_req0, b_req1;
  logic       b_we0 = 1'b0, b_we1 = 1'b0;
  logic [7:0] b_adr0 = 8'h01, b_adr1 = 8'h02, b_wd0 = 8'h00, b_wd1 = 8'h00;
  logic       b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_read_mem, b_write_mem;
  logic [7:0] b_rdata0, b_rdata1, b_mem_adr, b_mem_din;
  logic [7:0] b_mem_dout = 8'h3C;

`ifdef DAT_MEM_ARB_STATS_EN
  logic [15:0] gc0, gc1, cc, b_gc0, b_gc1, b_cc;
`endif

  dat_mem_arb #(.AW(8), .MaxBurst(4)) u_dut (
    .CLK(clk), .ResetN(rst_n),
    .Req0(req0), .Req1(req1), .We0(we0), .We1(we1),
    .Adr0(adr0), .Adr1(adr1), .Wdata0(wdata0), .Wdata1(wdata1),
    .Gnt0(gnt0), .Gnt1(gnt1), .Rdata0(rdata0), .Rdata1(rdata1),
    .RValid0(rvalid0), .RValid1(rvalid1),
    .MemAdr(mem_adr), .ReadMem(read_mem), .WriteMem(write_mem),
    .MemDataIn(mem_din), .MemDataOut(mem_dout)
`ifdef DAT_MEM_ARB_STATS_EN
    , .GntCnt0(gc0), .GntCnt1(gc1), .ConflictCnt(cc)
`endif
  );

  dat_mem_arb #(.AW(8), .MaxBurst(1)) u_dut_b (
    .CLK(clk), .ResetN(rst_n),
    .Req0(b_req0), .Req1(b_req1), .We0(b_we0), .We1(b_we1),
    .Adr0(b_adr0), .Adr1(b_adr1), .Wdata0(b_wd0), .Wdata1(b_wd1),
    .Gnt0(b_gnt0), .Gnt1(b_gnt1), .Rdata0(b_rdata0), .Rdata1(b_rdata1),
    .RValid0(b_rvalid0), .RValid1(b_rvalid1),
    .MemAdr(b_mem_adr), .ReadMem(b_read_mem), .WriteMem(b_write_mem),
    .MemDataIn(b_mem_din), .MemDataOut(b_mem_dout)
`ifdef DAT_MEM_ARB_STATS_EN
    , .GntCnt0(b_gc0), .GntCnt1(b_gc1), .ConflictCnt(b_cc)
`endif
  );

  // dat_mem model: combinational read, write at the clock edge; unwritten words read adr^8'h5A.
  logic [7:0]   mem [256];
  logic [255:0] wr_valid;
  assign mem_dout = wr_valid[mem_adr] ? mem[mem_adr] : (mem_adr ^ 8'h5A);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid <= '0;
    end else if (write_mem) begin
      wr_valid[mem_adr] <= 1'b1;
      mem[mem_adr]      <= mem_din;
    end
  end

  gexp_t gq[$];
  rexp_t rq[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected accesses and read returns as the DUT presents them.
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    if (rst_n === 1'b1) begin
      if (gnt0 || gnt1) begin
        if (gq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_gnt: got unexpected grant gnt1=%0b gnt0=%0b expected none", gnt1, gnt0);
        end else begin
          g = gq.pop_front();
          chk("sb_gnt_excl", {31'd0, gnt0 & gnt1}, 0);
          chk("sb_gnt_port", {31'd0, gnt1}, {31'd0, g.port});
          chk("sb_write_mem", {31'd0, write_mem}, {31'd0, g.we});
          chk("sb_read_mem", {31'd0, read_mem}, {31'd0, !g.we});
          chk("sb_mem_adr", {24'd0, mem_adr}, {24'd0, g.adr});
          chk("sb_mem_din", {24'd0, mem_din}, {24'd0, g.wd});
        end
      end else begin
        chk("sb_idle_bus", {14'd0, read_mem, write_mem, mem_adr, mem_din}, 0);
      end
      if (rvalid0 || rvalid1) begin
        if (rq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_rvalid: got unexpected rvalid1=%0b rvalid0=%0b expected none", rvalid1, rvalid0);
        end else begin
          r = rq.pop_front();
          chk("sb_rvalid_port", {30'd0, rvalid1, rvalid0}, r.port ? 32'd2 : 32'd1);
          chk("sb_rdata", {24'd0, r.port ? rdata1 : rdata0}, {24'd0, r.data});
        end
      end
    end
  end

  initial begin
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    adr0 = 0; adr1 = 0; wdata0 = 0; wdata1 = 0;
    b_req0 = 0; b_req1 = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 0);
    chk("rst_bus", {14'd0, read_mem, write_mem, mem_adr, mem_din}, 0);
    chk("rst_rd", {14'd0, rvalid1, rvalid0, rdata1, rdata0}, 0);
    step();
    step();
    rst_n = 1'b1;

    // Port 0 write A5 -> 0x10, then port 1 reads it back
    req0 = 1; we0 = 1; adr0 = 8'h10; wdata0 = 8'hA5;
    gq.push_back('{1'b0, 1'b1, 8'h10, 8'hA5});
    @(negedge clk) chk("t1_first_latency", {31'd0, gnt0}, 0);
    step();
    @(negedge clk);
    chk("t1_gnt0", {31'd0, gnt0}, 1);
    chk("t1_write_mem", {31'd0, write_mem}, 1);
    chk("t1_mem_adr", {24'd0, mem_adr}, 32'h10);
    step();
    req0 = 0; we0 = 0;
    step();
    req1 = 1; we1 = 0; adr1 = 8'h10; wdata1 = 8'h00;
    gq.push_back('{1'b1, 1'b0, 8'h10, 8'h00});
    rq.push_back('{1'b1, 8'hA5});
    step();
    @(negedge clk) chk("t1_gnt1", {31'd0, gnt1}, 1);
    step();
    req1 = 0;
    @(negedge clk);
    chk("t1_rvalid1", {31'd0, rvalid1}, 1);
    chk("t1_rdata1", {24'd0, rdata1}, 32'hA5);
    step();
    @(negedge clk) chk("t1_rvalid1_pulse", {31'd0, rvalid1}, 0);

    // Reset, then both request together: 0,0,0,0,1,1,1,1,0
    #2 rst_n = 1'b0;
    #1 chk("t2_rst_rdata1", {24'd0, rdata1}, 0);
    step();
    rst_n = 1'b1;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    adr0 = 8'h20; adr1 = 8'h21; wdata0 = 0; wdata1 = 0;
    for (int k = 0; k < 9; k++) begin
      logic p;
      p = (k >= 4) && (k < 8);
      gq.push_back('{p, 1'b0, p ? 8'h21 : 8'h20, 8'h00});
      rq.push_back('{p, p ? 8'h7B : 8'h7A});
    end
    step();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk) chk("t2_burst_gnt", {30'd0, gnt1, gnt0}, ((k >= 4) && (k < 8)) ? 32'd2 : 32'd1);
      step();
    end
    req0 = 0; req1 = 0;
    step();
    step();

    // Owner 0 releases after two accesses while port 1 waits
    req0 = 1; adr0 = 8'h30; adr1 = 8'h31;
    begin
      logic pat [7];
      pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 7; k++) begin
        gq.push_back('{pat[k], 1'b0, pat[k] ? 8'h31 : 8'h30, 8'h00});
        rq.push_back('{pat[k], pat[k] ? 8'h6B : 8'h6A});
      end
    end
    step();
    req1 = 1;
    @(negedge clk) chk("t3_gnt_a", {30'd0, gnt1, gnt0}, 1);
    step();
    @(negedge clk) chk("t3_gnt_b", {30'd0, gnt1, gnt0}, 1);
    step();
    req0 = 0;
    @(negedge clk) chk("t3_release_cycle", {30'd0, gnt1, gnt0}, 0);
    step();
    req0 = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) chk("t3_own1_burst", {30'd0, gnt1, gnt0}, 2);
      step();
    end
    @(negedge clk) chk("t3_back_to_0", {30'd0, gnt1, gnt0}, 1);
    step();
    req0 = 0; req1 = 0;
    step();
    step();

`ifdef DAT_MEM_ARB_STATS_EN
    chk("stats_conflict", {16'd0, cc}, 17);
    chk("stats_gnt0", {16'd0, gc0}, 8);
    chk("stats_gnt1", {16'd0, gc1}, 8);
`endif

    // Asynchronous reset during an OWN1 write
    req1 = 1; we1 = 1; adr1 = 8'h40; wdata1 = 8'h77;
    gq.push_back('{1'b1, 1'b1, 8'h40, 8'h77});
    step();
    @(negedge clk);
    chk("t4_gnt1", {31'd0, gnt1}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_gnt", {30'd0, gnt1, gnt0}, 0);
    chk("t4_rst_bus", {14'd0, read_mem, write_mem, mem_adr, mem_din}, 0);
    chk("t4_rst_rd", {14'd0, rvalid1, rvalid0, rdata1, rdata0}, 0);
    gq.push_back('{1'b1, 1'b1, 8'h40, 8'h77});
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk) chk("t4_post_rst_latency", {31'd0, gnt1}, 0);
    step();
    @(negedge clk) chk("t4_post_rst_gnt1", {31'd0, gnt1}, 1);
    step();
    req1 = 0; we1 = 0;
    step();
    step();

    // MaxBurst=1 instance: strict alternation
    b_req0 = 1; b_req1 = 1;
    step();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t5_alt_gnt", {30'd0, b_gnt1, b_gnt0}, k[0] ? 32'd2 : 32'd1);
      if (k > 0) begin
        chk("t5_rvalid", {30'd0, b_rvalid1, b_rvalid0}, k[0] ? 32'd1 : 32'd2);
        chk("t5_rdata", {24'd0, k[0] ? b_rdata0 : b_rdata1}, 32'h3C);
      end
      step();
    end
    b_req0 = 0; b_req1 = 0;
    step();
    step();

    chk("sb_gq_drained", gq.size(), 0);
    chk("sb_rq_drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
